// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic unit (mul32 / div32):
// FSM state encodings and the default operand width.
package arith_pkg;

    localparam int ARITH_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } arith_state_t;

endpackage : arith_pkg

// File: rtl/mul_step.sv
// One shift-add multiplier iteration: conditionally add the multiplicand
// into the accumulator, then shift {acc, shift} right by one bit.
// The accumulator carries one extra bit so the add carry is never lost.
module mul_step
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic [WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0] i_shift,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH:0]   o_acc,
    output logic [WIDTH-1:0] o_shift
);

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;

    // Add the multiplicand only when the current multiplier bit is set
    always_comb begin
        w_addend = i_shift[0] ? i_mcand : '0;
        w_sum    = i_acc + {1'b0, w_addend};
        o_acc    = {1'b0, w_sum[WIDTH:1]};
        o_shift  = {w_sum[0], i_shift[WIDTH-1:1]};
    end

endmodule : mul_step

// File: rtl/mul32.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle.
// start/done handshake matches div32; a start during DONE chains directly
// into the next operation.
module mul32
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     src1,
    input  logic [WIDTH-1:0]     src2,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    arith_state_t       r_state;
    arith_state_t       w_state_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH:0]     r_acc;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     w_acc_step;
    logic [WIDTH-1:0]   w_shift_step;
    logic               w_accept;
    logic               w_last;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .i_acc   (r_acc),
        .i_shift (r_shift),
        .i_mcand (r_mcand),
        .o_acc   (w_acc_step),
        .o_shift (w_shift_step)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a start is accepted in IDLE and DONE only
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_cnt == LAST_CNT);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_CALC;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: operand capture, iteration, and product load on the last step
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_mcand <= '0;
            r_shift <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
        end else if (w_accept) begin
            r_mcand <= src1;
            r_shift <= src2;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_CALC) begin
            r_acc   <= w_acc_step;
            r_shift <= w_shift_step;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_prod <= {w_acc_step[WIDTH-1:0], w_shift_step};
            end
        end
    end

    assign prod = r_prod;
    assign busy = (r_state == ST_CALC);
    assign done = (r_state == ST_DONE);

endmodule : mul32

// File: tb/tb_mul32.sv
// Directed bench for mul32: table of hand-computed products, then
// hand-written sequences for start-while-busy, back-to-back, mid-run
// reset and a divide/multiply round trip.
module tb_mul32;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [63:0] prod;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[10];

    mul32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .start (start),
        .src1  (src1),
        .src2  (src2),
        .prod  (prod),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Issue one operation from IDLE and check latency, busy span and product
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int n;
        int nb;
        start = 1'b1;
        src1  = a;
        src2  = b;
        @(posedge clk); #1;
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
        n  = 0;
        nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        chk({name, " latency"}, 64'(n + 1), 64'd33);
        chk({name, " busy_cycles"}, 64'(nb), 64'd32);
        chk({name, " busy_in_done"}, {63'd0, busy}, 64'd0);
        chk({name, " prod"}, prod, exp);
        @(posedge clk); #1;
        chk({name, " done_fall"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;

        vecs[0] = '{32'd7,          32'd5,          64'h23};
        vecs[1] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[2] = '{32'd0,          32'h12345678,   64'd0};
        vecs[3] = '{32'hFFFFFFFF,   32'd0,          64'd0};
        vecs[4] = '{32'd1,          32'd1,          64'd1};
        vecs[5] = '{32'd3,          32'h55555555,   64'hFFFFFFFF};
        vecs[6] = '{32'h80000000,   32'd2,          64'h100000000};
        vecs[7] = '{32'hFFFFFFFF,   32'd2,          64'h1FFFFFFFE};
        vecs[8] = '{32'h00010000,   32'h00010000,   64'h100000000};
        vecs[9] = '{32'h12345678,   32'h10,         64'h123456780};

        // Reset state
        n_rst = 1'b0;
        start = 1'b0;
        src1  = '0;
        src2  = '0;
        #12;
        chk("reset prod", prod, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("idle busy", {63'd0, busy}, 64'd0);

        // Table-driven products
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // start pulses during CALC are ignored
        start = 1'b1; src1 = 32'd6; src2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        pulses = 0;
        while (!done && n < 100) begin
            if (n >= 5 && n < 10) begin
                start = 1'b1; src1 = 32'd3; src2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("ignore latency", 64'(n + 1), 64'd33);
        chk("ignore prod", prod, 64'd54);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("ignore extra_done", 64'(pulses), 64'd0);

        // Back-to-back: start held during the DONE cycle
        start = 1'b1; src1 = 32'd2; src2 = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b first_prod", prod, 64'd8);
        start = 1'b1; src1 = 32'd10; src2 = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b busy_rise", {63'd0, busy}, 64'd1);
        chk("b2b done_fall", {63'd0, done}, 64'd0);
        chk("b2b prod_hold", prod, 64'd8);
        n = 1;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b gap", 64'(n), 64'd33);
        chk("b2b second_prod", prod, 64'd100);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of CALC
        start = 1'b1; src1 = 32'hDEADBEEF; src2 = 32'h01234567;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("midrst busy_before", {63'd0, busy}, 64'd1);
        n_rst = 1'b0;
        #1;
        chk("midrst prod", prod, 64'd0);
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst done", {63'd0, done}, 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        run_op("after_rst", 32'd12, 32'd12, 64'd144);

        // Round trip: (src1 / src2) * src2 + (src1 % src2) == src1
        for (int i = 0; i < 500; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 4 == 0) b = b >> ($urandom_range(31, 1));
            if (b == 32'd0) b = 32'd1;
            r = a % b;
            run_op("roundtrip", a / b, b, {32'd0, a - r});
            chk("roundtrip sum", prod + {32'd0, r}, {32'd0, a});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mul32
